fifo_collect: RTL
=================

# fifo_collect

Serial-to-parallel collector: accepts one BITS-wide word per handshake and assembles DEPTH words into a parallel vector, presented with a valid/ready handshake. Sits at the output edge of the systolic array, gathering the words a column streams out into a row for writeback. It is the counterpart of the parallel-load/shift-out transposer that feeds the array. Output ordering matches the transposer: the first word accepted appears at `q[0]`.

## Interface
- `DEPTH`, 8, words per vector (≥2)
- `BITS`, 64, word width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `d` holds a valid word
- `d`  in  BITS  input word
- `in_ready`  out  1  block can accept `d` this cycle
- `out_valid`  out  1  `q` holds a complete vector
- `out_ready`  in  1  consumer takes `q` this cycle
- `q`  out  BITS × [DEPTH-1:0] (unpacked)  assembled vector, `q[0]` = oldest word
- `fill_cnt`  out  $clog2(DEPTH+1)  words currently held
- `flush`  in  1  only with `FIFO_COLLECT_FLUSH_EN`; see Configuration

## Operation
- State machine, two states: FILL (collecting), FULL (vector presented).
- Reset: state FILL, `fill_cnt`=0, all `q[i]`=0, `out_valid`=0, `in_ready`=1.
- Input accept = `in_valid && in_ready`; output accept = `out_valid && out_ready`.
- FILL: `in_ready`=1, `out_valid`=0. On input accept, `q[fill_cnt]` <= `d`, `fill_cnt` += 1. When the accept makes `fill_cnt`=DEPTH, go to FULL.
- FULL: `out_valid`=1, `fill_cnt`=DEPTH, `q` stable. `in_ready` = `out_ready` (combinational pass-through, no bubble).
  - Output accept without input accept: `fill_cnt` <= 0, go to FILL. `q` keeps its stale contents; it is not cleared.
  - Output accept with input accept in the same cycle: `q[0]` <= `d`, `fill_cnt` <= 1, go to FILL. The consumer has sampled the old `q` on that edge.
  - No output accept: hold everything. Input is back-pressured.
- `d` is ignored whenever `in_valid`=0. Slots `q[i]` for i ≥ `fill_cnt` are don't-care while in FILL.
- `rst` mid-vector discards partial data and restores the reset values above on the next edge, regardless of state.

## Timing
- Latency: `out_valid` rises on the edge that accepts word DEPTH-1. At full rate that is DEPTH cycles after the first accept.
- Sustained throughput: one word per cycle, including across the FULL→FILL boundary when `out_ready`=1.
- `in_ready` has a combinational path from `out_ready` in FULL only. All other outputs are registered.
- `out_valid` never drops without an output accept. `q` never changes while `out_valid`=1.

## Configuration
- Macro: `FIFO_COLLECT_FLUSH_EN`.
- Defined: `flush` port exists.
  - `flush`=1 in FILL with `fill_cnt`>0: slots `fill_cnt`..DEPTH-1 are written 0, `fill_cnt` <= DEPTH, go to FULL.
  - If an input accept happens in the same cycle, the word goes into `q[fill_cnt]` first, then the remaining slots are zero-filled.
  - `flush` with `fill_cnt`=0, or while in FULL, is ignored.
- Not defined: no `flush` port. A vector completes only after DEPTH accepted words.

## Structure
- Package `fifo_collect_pkg`: state enum typedef `collect_state_t` {FILL, FULL}.
- `fill_cnt` width is computed locally from `DEPTH`.
- Single module, no sub-module. Datapath is a write-indexed register array, not a shift chain.

## Test plan
- Reset, then stream `d`=1..8 with `in_valid`=1 and `out_ready`=1 → `out_valid` on the cycle after the 8th accept, `q`={1..8}, `q[0]`=1; the next word 9 is accepted with no stall and lands in `q[0]`.
- Fill 8 words, hold `out_ready`=0 for 5 cycles while `in_valid`=1 → `in_ready`=0 and `q` unchanged throughout; on `out_ready`=1 both accepts happen in one cycle and `fill_cnt`=1.
- Sparse input: `in_valid` toggling 1,0,1,0 with values 0xA0..0xA7 → `q` holds exactly 0xA0..0xA7 in order; words presented with `in_valid`=0 are ignored.
- Assert `rst` after 5 words → `fill_cnt`=0, `out_valid`=0, `q` all zero; the next 8 words form a clean vector.
- With `FIFO_COLLECT_FLUSH_EN`: 3 words 0x11,0x22,0x33, then `flush` → `q`={0x11,0x22,0x33,0,0,0,0,0} and `out_valid`=1 on the next cycle. `flush` with `fill_cnt`=0 has no effect.

Source files
------------

// File: rtl/fifo_collect_pkg.sv
// Shared types for the column-output collector (fifo_collect).
package fifo_collect_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } collect_state_t;

endpackage

// File: rtl/fifo_collect.sv
// Serial-to-parallel collector: gathers DEPTH words into q[0..DEPTH-1], oldest at q[0].
// Optional `flush` port and zero-fill completion enabled by FIFO_COLLECT_FLUSH_EN.
module fifo_collect
    import fifo_collect_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [BITS-1:0]    d,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITS-1:0]    q [DEPTH-1:0],
    output logic [CNT_W-1:0]   fill_cnt
`ifdef FIFO_COLLECT_FLUSH_EN
    ,
    input  logic               flush
`endif
);

    collect_state_t          state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    vld_q;
    logic [BITS-1:0]         data_q [DEPTH-1:0];
    logic                    in_acc;
    logic                    out_acc;
    logic                    flush_go;

    // In FULL, a consumer taking q this cycle frees the array for the incoming word.
    assign in_ready  = (state_q == FILL) || out_ready;
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = vld_q && out_ready;
    assign out_valid = vld_q;
    assign fill_cnt  = cnt_q;
    assign q         = data_q;

`ifdef FIFO_COLLECT_FLUSH_EN
    assign flush_go = (state_q == FILL) && flush && (cnt_q != '0);
`else
    assign flush_go = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    // Incoming word takes slot cnt_q; a flush zero-fills everything above it.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (in_acc && (CNT_W'(i) == cnt_q)) begin
                            data_q[i] <= d;
                        end else if (flush_go && (CNT_W'(i) >= cnt_q)) begin
                            data_q[i] <= '0;
                        end
                    end
                    if (flush_go) begin
                        cnt_q   <= CNT_W'(DEPTH);
                        state_q <= FULL;
                        vld_q   <= 1'b1;
                    end else if (in_acc) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DEPTH - 1)) begin
                            state_q <= FULL;
                            vld_q   <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_acc) begin
                        state_q <= FILL;
                        vld_q   <= 1'b0;
                        if (in_acc) begin
                            data_q[0] <= d;
                            cnt_q     <= CNT_W'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
